// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions used by the memory arbiter.
//   - load/store funct3 encodings (LB..LHU, SB..SW)
//   - mem_arb_state_t: arbiter FSM states
//   - acc_size_t / acc_size(): access width decoded from funct3
//   - MEM_STROBE_W: byte-enable width of the memory port
package cpu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int MEM_STROBE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        MISAL = 2'd3
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_size_t;

    // Any code that is not a byte or halfword access is handled as a word.
    function automatic acc_size_t acc_size(input logic [2:0] funct3);
        if (funct3 == LB || funct3 == LBU)
            return ACC_BYTE;
        else if (funct3 == LH || funct3 == LHU)
            return ACC_HALF;
        else
            return ACC_WORD;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit word bus.
//   funct3    in  3   access size/sign
//   addr_lo   in  2   byte offset within the word
//   st_data   in  32  LSB-justified store data
//   ld_word   in  32  raw memory word
//   st_strobe out 4   byte enables for a store
//   st_wdata  out 32  store data replicated across lanes
//   ld_data   out 32  selected load lane, sign/zero-extended (funct3[2]=1 -> zero)
//   misalign  out 1   access does not fit its natural alignment
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [2:0]              funct3,
    input  logic [1:0]              addr_lo,
    input  logic [31:0]             st_data,
    input  logic [31:0]             ld_word,
    output logic [MEM_STROBE_W-1:0] st_strobe,
    output logic [31:0]             st_wdata,
    output logic [31:0]             ld_data,
    output logic                    misalign
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;
    logic               zero_ext;

    assign zero_ext = funct3[2];

    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        st_strobe = 4'b1111;
        st_wdata  = st_data;
        ld_data   = ld_word;
        misalign  = 1'b0;
        case (acc_size(funct3))
            ACC_BYTE: begin
                st_strobe = 4'b0001 << addr_lo;
                st_wdata  = {4{st_data[7:0]}};
                ld_data   = zero_ext ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            ACC_HALF: begin
                st_strobe = 4'b0011 << {addr_lo[1], 1'b0};
                st_wdata  = {2{st_data[15:0]}};
                ld_data   = zero_ext ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
                misalign  = addr_lo[0];
            end
            default: begin
                misalign  = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory bus between instruction fetch and
// load/store data accesses, one transaction at a time.
//   Parameter TIMEOUT_CYCLES: busy cycles tolerated before a transaction aborts.
//   Fetch side : if_req, if_addr -> if_rdata, if_done
//   Data side  : d_read, d_write, d_funct3, d_addr, d_wdata
//                -> d_rdata, d_done, d_misalign
//   Shared     : timeout (qualifies if_done/d_done)
//   Memory     : m_read, m_write, m_addr, m_wdata, m_strobe <- m_rdata, m_busy
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants when both requesters
// are pending; otherwise data always has priority over fetch.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic [31:0]             if_rdata,
    output logic                    if_done,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [2:0]              d_funct3,
    input  logic [31:0]             d_addr,
    input  logic [31:0]             d_wdata,
    output logic [31:0]             d_rdata,
    output logic                    d_done,
    output logic                    d_misalign,
    output logic                    timeout,
    output logic                    m_read,
    output logic                    m_write,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    output logic [MEM_STROBE_W-1:0] m_strobe,
    input  logic [31:0]             m_rdata,
    input  logic                    m_busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    mem_arb_state_t state;

    logic [2:0]       op_funct3;
    logic [1:0]       op_lo;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_cnt_inc;

    logic d_pend;
    logic f_pend;
    logic grant_data;
    logic grant_fetch;

    logic [2:0]              lane_funct3;
    logic [1:0]              lane_lo;
    logic [MEM_STROBE_W-1:0] lane_strobe;
    logic [31:0]             lane_wdata;
    logic [31:0]             lane_ldata;
    logic                    lane_misal;

    logic [31:0] d_word_addr;
    logic [31:0] f_word_addr;

    // A requester in its done cycle is still holding the old request.
    assign d_pend = (d_read | d_write) & ~d_done;
    assign f_pend = if_req & ~if_done;

    assign d_word_addr = d_addr & ~32'd3;
    assign f_word_addr = if_addr & ~32'd3;

    assign busy_cnt_inc = (busy_cnt == CNT_MAX) ? busy_cnt : busy_cnt + CNT_W'(1);

    // One lane aligner serves both directions: in IDLE it looks at the
    // incoming request (strobe, replication, alignment); during a data
    // transaction it looks at the registered access to extend the load.
    assign lane_funct3 = (state == IDLE) ? d_funct3 : op_funct3;
    assign lane_lo     = (state == IDLE) ? d_addr[1:0] : op_lo;

    mem_lane_align u_lane (
        .funct3    (lane_funct3),
        .addr_lo   (lane_lo),
        .st_data   (d_wdata),
        .ld_word   (m_rdata),
        .st_strobe (lane_strobe),
        .st_wdata  (lane_wdata),
        .ld_data   (lane_ldata),
        .misalign  (lane_misal)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;  // 0 = fetch granted last, 1 = data granted last

    always_comb begin
        grant_data  = d_pend;
        grant_fetch = f_pend & ~d_pend;
        if (d_pend && f_pend) begin
            grant_data  = ~last_grant;
            grant_fetch = last_grant;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            last_grant <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_data)
                last_grant <= 1'b1;
            else if (grant_fetch)
                last_grant <= 1'b0;
        end
    end
`else
    always_comb begin
        grant_data  = d_pend;
        grant_fetch = f_pend & ~d_pend;
    end
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= 32'd0;
            m_wdata    <= 32'd0;
            m_strobe   <= '0;
            op_funct3  <= 3'd0;
            op_lo      <= 2'd0;
            busy_cnt   <= '0;
            if_rdata   <= 32'd0;
            if_done    <= 1'b0;
            d_rdata    <= 32'd0;
            d_done     <= 1'b0;
            d_misalign <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            d_misalign <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        if (lane_misal) begin
                            state      <= MISAL;
                            d_done     <= 1'b1;
                            d_misalign <= 1'b1;
                            d_rdata    <= 32'd0;
                        end else begin
                            // A simultaneous read and write resolves to the write.
                            state     <= DATA;
                            m_read    <= ~d_write;
                            m_write   <= d_write;
                            m_addr    <= d_word_addr;
                            m_wdata   <= d_write ? lane_wdata : 32'd0;
                            m_strobe  <= d_write ? lane_strobe : 4'b1111;
                            op_funct3 <= d_funct3;
                            op_lo     <= d_addr[1:0];
                            busy_cnt  <= '0;
                        end
                    end else if (grant_fetch) begin
                        state    <= FETCH;
                        m_read   <= 1'b1;
                        m_addr   <= f_word_addr;
                        m_wdata  <= 32'd0;
                        m_strobe <= 4'b1111;
                        busy_cnt <= '0;
                    end
                end
                FETCH, DATA: begin
                    if (!m_busy) begin
                        state   <= IDLE;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (state == FETCH) begin
                            if_done  <= 1'b1;
                            if_rdata <= m_rdata;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= m_write ? 32'd0 : lane_ldata;
                        end
                    end else if (busy_cnt_inc == CNT_MAX) begin
                        // This busy sample is the last one tolerated: abort.
                        state    <= IDLE;
                        m_read   <= 1'b0;
                        m_write  <= 1'b0;
                        busy_cnt <= busy_cnt_inc;
                        timeout  <= 1'b1;
                        if (state == FETCH) begin
                            if_done  <= 1'b1;
                            if_rdata <= 32'd0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= 32'd0;
                        end
                    end else begin
                        busy_cnt <= busy_cnt_inc;
                    end
                end
                MISAL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed transactions for mem_arbiter (default build,
// TIMEOUT_CYCLES = 4). A transaction-level model fills per-cycle stimulus and
// expectation tables; one process compares the DUT against them every cycle.
module tb_mem_arbiter;

    localparam int TMO  = 4;
    localparam int NC   = 80;
    localparam int LAST = 72;

    logic        clk = 1'b0;
    logic        nRst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_read;
    logic        d_write;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_misalign;
    logic        timeout;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strobe;
    logic [31:0] m_rdata;
    logic        m_busy;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .nRst(nRst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_read(d_read), .d_write(d_write), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_misalign(d_misalign),
        .timeout(timeout),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_strobe(m_strobe), .m_rdata(m_rdata), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cur    = 0;
    bit run    = 1'b0;

    // stimulus tables
    logic        a_if_req  [NC];
    logic [31:0] a_if_addr [NC];
    logic        a_d_read  [NC];
    logic        a_d_write [NC];
    logic [2:0]  a_f3      [NC];
    logic [31:0] a_d_addr  [NC];
    logic [31:0] a_d_wdata [NC];
    logic        a_busy    [NC];
    logic [31:0] a_mrdata  [NC];
    // expectation tables
    logic        e_m_read  [NC];
    logic        e_m_write [NC];
    logic [31:0] e_m_addr  [NC];
    logic [3:0]  e_strobe  [NC];
    logic [31:0] e_wdata   [NC];
    logic        e_if_done [NC];
    logic [31:0] e_if_rd   [NC];
    logic        e_d_done  [NC];
    logic        e_chk_d   [NC];
    logic [31:0] e_d_rd    [NC];
    logic        e_misal   [NC];
    logic        e_tmo     [NC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cur, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
        int     sz   = acc_bytes(f3);
        int     base = (int'(addr % 4) / sz) * sz;
        longint v    = 0;
        for (int i = sz - 1; i >= 0; i--)
            v = v * 256 + longint'((w >> (8 * (base + i))) & 32'd255);
        if (sz < 4 && !f3[2] && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] st_strobe_model(input logic [2:0] f3, input logic [31:0] addr);
        int         sz   = acc_bytes(f3);
        int         base = (int'(addr % 4) / sz) * sz;
        logic [3:0] s    = 4'd0;
        for (int i = 0; i < 4; i++)
            s[i] = (i >= base) && (i < base + sz);
        return s;
    endfunction

    function automatic logic [31:0] st_wdata_model(input logic [2:0] f3, input logic [31:0] d);
        int          sz = acc_bytes(f3);
        logic [31:0] r  = 32'd0;
        for (int i = 0; i < 4; i++)
            r = r | (((d >> (8 * (i % sz))) & 32'd255) << (8 * i));
        return r;
    endfunction

    // One transaction: request visible from cycle req, sampled at the edge
    // ending cycle g; memory stays busy for w cycles once the command is up.
    task automatic txn(input bit fetch, input int req, input int g, input int w,
                       input bit wr, input bit rd_too, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [31:0] mword);
        int done;
        bit mis;
        bit tmo;
        int sz;
        sz  = fetch ? 4 : acc_bytes(f3);
        mis = !fetch && (int'(addr % 32'(sz)) != 0);
        tmo = !mis && (w >= TMO);
        if (mis)      done = g + 1;
        else if (tmo) done = g + TMO + 1;
        else          done = g + w + 2;
        for (int c = req; c < done; c++) begin
            if (fetch) begin
                a_if_req[c]  = 1'b1;
                a_if_addr[c] = addr;
            end else begin
                a_d_read[c]  = !wr || rd_too;
                a_d_write[c] = wr;
                a_f3[c]      = f3;
                a_d_addr[c]  = addr;
                a_d_wdata[c] = wdat;
            end
        end
        if (!mis) begin
            for (int c = g + 1; c < done; c++) begin
                e_m_read[c]  = !wr;
                e_m_write[c] = wr;
                e_m_addr[c]  = addr & ~32'd3;
                e_strobe[c]  = wr ? st_strobe_model(f3, addr) : 4'b1111;
                e_wdata[c]   = st_wdata_model(f3, wdat);
            end
            for (int c = g + 1; c <= g + w && c < NC; c++)
                a_busy[c] = 1'b1;
            if (!tmo)
                a_mrdata[g + w + 1] = mword;
        end
        e_tmo[done] = tmo;
        if (fetch) begin
            e_if_done[done] = 1'b1;
            e_if_rd[done]   = tmo ? 32'd0 : mword;
        end else begin
            e_d_done[done] = 1'b1;
            e_misal[done]  = mis;
            if (!wr && !mis) begin
                e_chk_d[done] = 1'b1;
                e_d_rd[done]  = tmo ? 32'd0 : ld_model(f3, addr, mword);
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run) begin
            chk("m_read", {31'd0, m_read}, {31'd0, e_m_read[cur]});
            chk("m_write", {31'd0, m_write}, {31'd0, e_m_write[cur]});
            chk("if_done", {31'd0, if_done}, {31'd0, e_if_done[cur]});
            chk("d_done", {31'd0, d_done}, {31'd0, e_d_done[cur]});
            chk("d_misalign", {31'd0, d_misalign}, {31'd0, e_misal[cur]});
            chk("timeout", {31'd0, timeout}, {31'd0, e_tmo[cur]});
            if (e_m_read[cur] || e_m_write[cur]) begin
                chk("m_addr", m_addr, e_m_addr[cur]);
                chk("m_strobe", {28'd0, m_strobe}, {28'd0, e_strobe[cur]});
            end
            if (e_m_write[cur])
                chk("m_wdata", m_wdata, e_wdata[cur]);
            if (e_if_done[cur])
                chk("if_rdata", if_rdata, e_if_rd[cur]);
            if (e_chk_d[cur])
                chk("d_rdata", d_rdata, e_d_rd[cur]);
        end
    end

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        d_read = 1'b0; d_write = 1'b0; d_funct3 = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        m_busy = 1'b0; m_rdata = 32'hDEADBEEF;
    endtask

    initial begin
        nRst = 1'b0;
        clear_inputs();

        for (int c = 0; c < NC; c++) begin
            a_if_req[c] = 0; a_if_addr[c] = 0; a_d_read[c] = 0; a_d_write[c] = 0;
            a_f3[c] = 0; a_d_addr[c] = 0; a_d_wdata[c] = 0; a_busy[c] = 0;
            a_mrdata[c] = 32'hDEADBEEF;
            e_m_read[c] = 0; e_m_write[c] = 0; e_m_addr[c] = 0; e_strobe[c] = 0;
            e_wdata[c] = 0; e_if_done[c] = 0; e_if_rd[c] = 0; e_d_done[c] = 0;
            e_chk_d[c] = 0; e_d_rd[c] = 0; e_misal[c] = 0; e_tmo[c] = 0;
        end

        // model pinned against hand-computed values
        chk("model_lb", ld_model(3'b000, 32'h203, 32'h80000000), 32'hFFFFFF80);
        chk("model_lbu", ld_model(3'b100, 32'h203, 32'h80000000), 32'h00000080);
        chk("model_lh", ld_model(3'b001, 32'h202, 32'h80010000), 32'hFFFF8001);
        chk("model_sb_strobe", {28'd0, st_strobe_model(3'b000, 32'h203)}, 32'h8);
        chk("model_sh_strobe", {28'd0, st_strobe_model(3'b001, 32'h206)}, 32'hC);
        chk("model_sb_wdata", st_wdata_model(3'b000, 32'h000000AB), 32'hABABABAB);

        //  fetch  req   g   w  wr rd2 f3      addr          wdata         mem word
        txn(1'b1,  1,   1,  0, 0, 0, 3'b010, 32'h00000100, 32'h0,        32'h00A00093);
        txn(1'b0,  5,   5,  1, 1, 0, 3'b000, 32'h00000203, 32'h000000AB, 32'h0);
        txn(1'b0, 10,  10,  0, 0, 0, 3'b000, 32'h00000203, 32'h0,        32'h80000000);
        txn(1'b0, 14,  14,  0, 0, 0, 3'b100, 32'h00000203, 32'h0,        32'h80000000);
        txn(1'b0, 18,  18,  2, 0, 0, 3'b001, 32'h00000202, 32'h0,        32'h80010000);
        txn(1'b0, 24,  24,  0, 0, 0, 3'b101, 32'h00000200, 32'h0,        32'h1234F00D);
        txn(1'b0, 28,  28,  0, 1, 0, 3'b001, 32'h00000206, 32'h00005678, 32'h0);
        txn(1'b0, 32,  32,  0, 1, 1, 3'b010, 32'h00000208, 32'hCAFEF00D, 32'h0);
        txn(1'b0, 36,  36,  0, 0, 0, 3'b010, 32'h00000202, 32'h0,        32'h0);
        txn(1'b0, 39,  39,  0, 0, 0, 3'b001, 32'h00000201, 32'h0,        32'h0);
        // contention: data wins, fetch granted at the edge ending d_done
        txn(1'b0, 42,  42,  0, 0, 0, 3'b010, 32'h00000200, 32'h0,        32'h76543210);
        txn(1'b1, 42,  44,  0, 0, 0, 3'b010, 32'h00000104, 32'h0,        32'h00100113);
        // busy outlasts the limit, then a normal request
        txn(1'b0, 48,  48,  5, 0, 0, 3'b010, 32'h00000300, 32'h0,        32'h0);
        txn(1'b1, 55,  55,  0, 0, 0, 3'b010, 32'h00000108, 32'h0,        32'h00000013);
        txn(1'b0, 59,  59,  0, 0, 0, 3'b110, 32'h0000020C, 32'h0,        32'h89ABCDEF);
        txn(1'b0, 63,  63,  3, 1, 0, 3'b000, 32'h00000201, 32'h0000005A, 32'h0);

        // reset state
        #12;
        chk("rst_m_read", {31'd0, m_read}, 32'd0);
        chk("rst_m_write", {31'd0, m_write}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_strobe", {28'd0, m_strobe}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_dones", {28'd0, if_done, d_done, d_misalign, timeout}, 32'd0);

        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c <= LAST; c++) begin
            cur      = c;
            if_req   = a_if_req[c];
            if_addr  = a_if_addr[c];
            d_read   = a_d_read[c];
            d_write  = a_d_write[c];
            d_funct3 = a_f3[c];
            d_addr   = a_d_addr[c];
            d_wdata  = a_d_wdata[c];
            m_busy   = a_busy[c];
            m_rdata  = a_mrdata[c];
            run      = 1'b1;
            @(posedge clk);
            #1;
        end
        run = 1'b0;
        clear_inputs();

        // reset in the middle of a busy store
        d_write = 1'b1; d_funct3 = 3'b010; d_addr = 32'h400; d_wdata = 32'h01020304;
        m_busy = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_m_write", {31'd0, m_write}, 32'd1);
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_async_m_write", {31'd0, m_write}, 32'd0);
        chk("rst_async_m_read", {31'd0, m_read}, 32'd0);
        clear_inputs();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", {31'd0, d_done}, 32'd0);
        end
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;
        d_read = 1'b1; d_funct3 = 3'b010; d_addr = 32'h404; m_rdata = 32'h11223344;
        chk("post_rst_idle_done", {31'd0, d_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_m_read", {31'd0, m_read}, 32'd1);
        chk("post_rst_m_addr", m_addr, 32'h404);
        chk("post_rst_cmd_done", {31'd0, d_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_d_done", {31'd0, d_done}, 32'd1);
        chk("post_rst_d_rdata", d_rdata, 32'h11223344);
        d_read = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_done_pulse", {31'd0, d_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the CPU's single memory bus between the instruction-fetch requester and the load/store data requester driven by the control decoder's memRead/memWrite and funct3. Grants one transaction at a time and drives a word-aligned memory port with byte strobes. Waits out memory busy cycles, with a timeout. Returns fetched instructions and sign/zero-extended load data with one-cycle done pulses.

## Interface
- TIMEOUT_CYCLES, 255: maximum busy cycles per transaction before abort (≥1)
- clk  in  1  rising-edge clock
- nRst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address (word aligned by requester)
- if_rdata  out  32  fetched instruction, valid with if_done
- if_done  out  1  one-cycle fetch completion pulse
- d_read  in  1  load request (decoder memRead), held until d_done
- d_write  in  1  store request (decoder memWrite), held until d_done
- d_funct3  in  3  access size/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, LSB-justified
- d_rdata  out  32  extended load data, valid with d_done
- d_done  out  1  one-cycle data completion pulse
- d_misalign  out  1  with d_done: access rejected as misaligned
- timeout  out  1  with if_done/d_done: transaction aborted
- m_read, m_write  out  1 each  memory command, held through the transaction
- m_addr  out  32  {addr[31:2], 2'b00}
- m_wdata  out  32  lane-replicated store data
- m_strobe  out  4  byte enables (4'b1111 on reads)
- m_rdata  in  32  memory read word, valid in first cycle m_busy=0
- m_busy  in  1  memory not yet complete

## Operation
- States: IDLE, FETCH, DATA, MISAL.
- IDLE: evaluates requests. A requester whose done is high this cycle is ignored.
- IDLE to DATA or FETCH: registers address, strobe, wdata and funct3, then asserts m_read/m_write from the next cycle.
- IDLE to MISAL: taken on a misaligned data request. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- MISAL: no bus command is issued. d_done=1 and d_misalign=1 for one cycle, then returns to IDLE.
- Arbitration (default): fixed priority, data over fetch.
- d_read and d_write both high: the access is a write and the read is ignored.
- Unlisted funct3 codes (011, 110, 111): treated as word.
- FETCH/DATA exit on m_busy low: in the first cycle m_busy is sampled low, the arbiter captures and extends m_rdata, drops the command, and returns to IDLE. The done pulse occurs in the next cycle.
- Busy counter: counts sampled-busy cycles and reaches TIMEOUT_CYCLES only while m_busy is high.
- FETCH/DATA exit on timeout: when the counter reaches TIMEOUT_CYCLES, the transaction aborts. done and timeout pulse together, rdata=0, state returns to IDLE.
- Stores:
  - SB: strobe 4'b0001<<addr[1:0], wdata {4{d_wdata[7:0]}}.
  - SH: strobe 4'b0011<<{addr[1],1'b0}, wdata {2{d_wdata[15:0]}}.
  - SW: strobe 4'b1111, wdata d_wdata.
- Loads:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword lane addr[1], sign- or zero-extended.
  - LW: full word.
- Request dropped mid-transaction: the transaction completes and done still pulses.

## Timing
- Reset values: state IDLE. All outputs are 0, including m_strobe and the rdata registers.
- Reset asserted mid-transaction: m_read/m_write drop asynchronously and no done is produced.
- Latency: request sampled at edge N, command from cycle N+1. With zero-wait memory (m_busy=0 in N+1), done is high in cycle N+2.
- Each busy cycle adds one cycle of latency.
- Misaligned access: done and misalign are high in cycle N+1.
- Earliest next grant: the edge ending the done cycle. The requester must drop or change its request in its done cycle.
- Busy counter width: $clog2(TIMEOUT_CYCLES+1). It clears on entry to FETCH/DATA and saturates at TIMEOUT_CYCLES.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - A last_grant flop (reset 0 = fetch) is added.
  - When both requesters are pending in IDLE, the requester not granted last wins.
  - A single pending requester always wins.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority, no extra state.

## Structure
- cpu_pkg gains:
  - mem_arb_state_t enum (IDLE, FETCH, DATA, MISAL);
  - load/store funct3 constants, reusing the existing LB..LHU and SB..SW;
  - MEM_STROBE_W = 4.
- One sub-module, mem_lane_align: combinational store replication/strobe generation and load lane select/extension, instantiated twice or shared.

## Test plan
- Zero-wait fetch: if_req, if_addr=0x100, m_rdata=0x00A00093 with m_busy=0 → m_read/m_addr=0x100 in cycle 1; if_done, if_rdata=0x00A00093 in cycle 2.
- Contention: if_req and d_read (LW 0x200) together, with a memory answering in one cycle:
  - default build → data is granted first; fetch command starts the cycle after d_done.
  - MEM_ARB_ROUND_ROBIN_EN build → fetch is granted first.
- Byte access: SB d_addr=0x203, d_wdata=0xAB → m_strobe=4'b1000, m_wdata=0xABABABAB. LB 0x203 with m_rdata=0x80000000 → d_rdata=0xFFFFFF80; LBU → 0x00000080.
- Misalign: LW d_addr=0x202 → no m_read, d_done and d_misalign high in cycle 1.
- Timeout: TIMEOUT_CYCLES=4, m_busy held high → d_done and timeout high, d_rdata=0, command dropped; the next request is served normally.
- Reset: nRst low while in DATA with m_busy=1 → m_write=0 immediately, no d_done; after release, state IDLE and a new request is served.
